// File: rtl/if_id_skid_reg.sv
// IF/ID boundary register with valid/ready handshake and a 2-entry skid buffer.
// in_ready decodes registered state only, so decode stalls never reach fetch combinationally.
module if_id_skid_reg #(
    parameter int                 NPC_W     = 32,
    parameter int                 INSTR_W   = 32,
    parameter logic [INSTR_W-1:0] NOP_INSTR = '0
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [NPC_W-1:0]   npc_in,
    input  logic [INSTR_W-1:0] instr_in,
    input  logic               flush,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [NPC_W-1:0]   npc_out,
    output logic [INSTR_W-1:0] instr_out,
    output logic [1:0]         occupancy
);
    typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;

    typedef struct packed {
        logic [NPC_W-1:0]   npc;
        logic [INSTR_W-1:0] instr;
    } entry_t;

    state_t state;
    entry_t main_q, skid_q, in_beat;
    logic   accept, pop;

    assign in_beat   = '{npc: npc_in, instr: instr_in};
    assign in_ready  = (state != TWO);
    assign out_valid = (state != EMPTY);
    assign accept    = in_valid & in_ready;
    assign pop       = out_valid & out_ready;

    assign npc_out   = main_q.npc;
    assign instr_out = main_q.instr;

    always_comb begin
        occupancy = 2'd0;
        case (state)
            ONE:     occupancy = 2'd1;
            TWO:     occupancy = 2'd2;
            default: occupancy = 2'd0;
        endcase
    end

    // Main register always holds the head; skid only fills when head is stalled.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state        <= EMPTY;
            main_q.npc   <= '0;
            main_q.instr <= NOP_INSTR;
            skid_q       <= '0;
        end else if (flush) begin
            state        <= EMPTY;
            main_q.instr <= NOP_INSTR;
        end else begin
            case (state)
                EMPTY: begin
                    if (accept) begin
                        state  <= ONE;
                        main_q <= in_beat;
                    end
                end
                ONE: begin
                    if (accept && pop) begin
                        main_q <= in_beat;
                    end else if (accept) begin
                        state  <= TWO;
                        skid_q <= in_beat;
                    end else if (pop) begin
                        state        <= EMPTY;
                        main_q.instr <= NOP_INSTR;
                    end
                end
                TWO: begin
                    if (pop) begin
                        state  <= ONE;
                        main_q <= skid_q;
                    end
                end
                default: state <= EMPTY;
            endcase
        end
    end
endmodule

// File: tb/tb_if_id_skid_reg.sv
// Directed vector table plus a queue-scoreboard sequence for if_id_skid_reg.
module tb_if_id_skid_reg;
    logic        clock = 1'b0;
    logic        reset, in_valid, in_ready, flush, out_valid, out_ready;
    logic [31:0] npc_in, instr_in, npc_out, instr_out;
    logic [1:0]  occupancy;

    int errors = 0;
    int checks = 0;

    localparam logic [31:0] IA = 32'hA000_0001;
    localparam logic [31:0] IB = 32'hB000_0002;
    localparam logic [31:0] IC = 32'hC000_0003;
    localparam logic [31:0] ID = 32'hD000_0004;

    always #5 clock = ~clock;

    if_id_skid_reg dut (
        .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .npc_in(npc_in), .instr_in(instr_in), .flush(flush), .out_valid(out_valid),
        .out_ready(out_ready), .npc_out(npc_out), .instr_out(instr_out),
        .occupancy(occupancy)
    );

    typedef struct {
        logic        rst_n, fl, iv;
        logic [31:0] npc, instr;
        logic        ordy;
        logic        e_ov, e_ir;
        logic [31:0] e_npc, e_instr;
        logic [1:0]  e_occ;
    } vec_t;

    vec_t tv[$];

    task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s @%0d: got %0h expected %0h", nm, idx, act, exp);
        end
    endtask

    task automatic add(input logic rst_n, fl, iv, input logic [31:0] npc, instr, input logic ordy,
                       input logic e_ov, e_ir, input logic [31:0] e_npc, e_instr, input logic [1:0] e_occ);
        vec_t v;
        v = '{rst_n, fl, iv, npc, instr, ordy, e_ov, e_ir, e_npc, e_instr, e_occ};
        tv.push_back(v);
    endtask

    task automatic drive(input logic rst_n, fl, iv, input logic [31:0] npc, instr, input logic ordy);
        reset = rst_n; flush = fl; in_valid = iv; npc_in = npc; instr_in = instr; out_ready = ordy;
    endtask

    initial begin
        logic [31:0] q_npc[$], q_instr[$];
        logic        iv, ordy, acc, pp;
        logic [31:0] seq_npc;

        drive(1'b0, 1'b0, 1'b0, '0, '0, 1'b0);
        //   rst fl iv npc  instr ordy | ov ir npc  instr occ
        add(0, 0, 1, 4,  IA, 0,  0, 1, 0,  0,  0);  // reset with in_valid high
        add(0, 0, 1, 4,  IA, 0,  0, 1, 0,  0,  0);
        add(1, 0, 1, 4,  IA, 1,  1, 1, 4,  IA, 1);  // streaming
        add(1, 0, 1, 8,  IB, 1,  1, 1, 8,  IB, 1);
        add(1, 0, 1, 12, IC, 1,  1, 1, 12, IC, 1);
        add(1, 0, 0, 0,  0,  1,  0, 1, 12, 0,  0);
        add(1, 0, 1, 4,  IA, 0,  1, 1, 4,  IA, 1);  // back-pressure
        add(1, 0, 1, 8,  IB, 0,  1, 0, 4,  IA, 2);
        add(1, 0, 1, 12, IC, 0,  1, 0, 4,  IA, 2);  // C held off
        add(1, 0, 1, 12, IC, 1,  1, 1, 8,  IB, 1);  // pop from TWO, C still refused
        add(1, 0, 1, 12, IC, 1,  1, 1, 12, IC, 1);
        add(1, 0, 0, 0,  0,  1,  0, 1, 12, 0,  0);
        add(1, 0, 1, 4,  IA, 0,  1, 1, 4,  IA, 1);  // flush from TWO
        add(1, 0, 1, 8,  IB, 0,  1, 0, 4,  IA, 2);
        add(1, 1, 1, 12, IC, 0,  0, 1, 4,  0,  0);
        add(1, 0, 0, 0,  0,  1,  0, 1, 4,  0,  0);
        add(1, 0, 1, 4,  IA, 0,  1, 1, 4,  IA, 1);  // reset mid-operation
        add(1, 0, 1, 8,  IB, 0,  1, 0, 4,  IA, 2);
        add(0, 1, 1, 12, IC, 1,  0, 1, 0,  0,  0);
        add(1, 0, 0, 0,  0,  1,  0, 1, 0,  0,  0);
        add(1, 0, 1, 4,  IA, 0,  1, 1, 4,  IA, 1);  // accept and pop together in ONE
        add(1, 0, 1, 8,  IB, 1,  1, 1, 8,  IB, 1);
        add(1, 0, 0, 0,  0,  1,  0, 1, 8,  0,  0);
        add(1, 0, 1, 16, ID, 0,  1, 1, 16, ID, 1);  // hold in ONE
        add(1, 0, 0, 0,  0,  0,  1, 1, 16, ID, 1);
        add(1, 1, 0, 0,  0,  1,  0, 1, 16, 0,  0);  // flush beats pop
        add(1, 1, 1, 20, IA, 0,  0, 1, 16, 0,  0);  // flush drops beat in EMPTY

        for (int i = 0; i < tv.size(); i++) begin
            drive(tv[i].rst_n, tv[i].fl, tv[i].iv, tv[i].npc, tv[i].instr, tv[i].ordy);
            @(posedge clock); #1;
            chk("out_valid", i, {31'd0, out_valid}, {31'd0, tv[i].e_ov});
            chk("in_ready",  i, {31'd0, in_ready},  {31'd0, tv[i].e_ir});
            chk("npc_out",   i, npc_out,            tv[i].e_npc);
            chk("instr_out", i, instr_out,          tv[i].e_instr);
            chk("occupancy", i, {30'd0, occupancy}, {30'd0, tv[i].e_occ});
        end

        // Stalled TWO: outputs must stay stable for several cycles, then drain in order.
        drive(1, 0, 1, 40, IA, 0); @(posedge clock); #1;
        drive(1, 0, 1, 44, IB, 0); @(posedge clock); #1;
        for (int k = 0; k < 3; k++) begin
            drive(1, 0, 1, 48, IC, 0); @(posedge clock); #1;
            chk("stall_npc", k, npc_out, 40);
            chk("stall_instr", k, instr_out, IA);
        end
        drive(1, 0, 0, 0, 0, 1); @(posedge clock); #1;
        chk("drain1_npc", 0, npc_out, 44);
        chk("drain1_instr", 0, instr_out, IB);
        @(posedge clock); #1;
        chk("drain2_valid", 0, {31'd0, out_valid}, 0);

        // Queue scoreboard under pseudo-random valid/ready patterns.
        seq_npc = 32'h100;
        for (int c = 0; c < 80; c++) begin
            iv   = ($urandom_range(0, 2) != 0);
            ordy = ($urandom_range(0, 3) != 0);
            acc  = iv && (q_npc.size() < 2);
            pp   = ordy && (q_npc.size() > 0);
            drive(1, 0, iv, seq_npc, seq_npc ^ 32'h5A5A_0000, ordy);
            @(posedge clock); #1;
            if (pp) begin
                void'(q_npc.pop_front());
                void'(q_instr.pop_front());
            end
            if (acc) begin
                q_npc.push_back(seq_npc);
                q_instr.push_back(seq_npc ^ 32'h5A5A_0000);
                seq_npc = seq_npc + 4;
            end
            chk("sb_occ", c, {30'd0, occupancy}, q_npc.size());
            chk("sb_in_ready", c, {31'd0, in_ready}, {31'd0, q_npc.size() < 2});
            if (q_npc.size() > 0) begin
                chk("sb_npc", c, npc_out, q_npc[0]);
                chk("sb_instr", c, instr_out, q_instr[0]);
            end else begin
                chk("sb_nop", c, instr_out, 0);
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
